// File: rtl/byte_fetch_ctrl.sv
// Byte-fetch controller for an arithmetic decoder: two init bytes, then one byte per
// request_byte bin step; stalls in WAIT_BYTE until the byte source catches up.
module byte_fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [3:0]  bn_next,
    input  logic        bn_req_byte,
    output logic [3:0]  m_bitsNeeded,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [7:0]  byte_out,
    output logic        byte_out_valid,
    output logic [1:0]  byte_out_sel,
    output logic        init_done,
    output logic [15:0] byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT0,
        S_INIT1,
        S_RUN,
        S_WAIT_BYTE
    } state_t;

    localparam logic [3:0] BN_RESET = 4'b1000;   // -8

    localparam logic [1:0] SEL_HI  = 2'd0;
    localparam logic [1:0] SEL_LO  = 2'd1;
    localparam logic [1:0] SEL_RUN = 2'd2;

    state_t      state_q;
    logic [3:0]  bn_q;
    logic [3:0]  pending_bn_q;
    logic [7:0]  byte_out_q;
    logic        byte_out_valid_q;
    logic [1:0]  byte_out_sel_q;
    logic [15:0] byte_cnt_q;

    logic        consume;
    logic [3:0]  bn_next_sat;

    // A non-negative bitsNeeded is a datapath fault; fall back to a fresh byte boundary.
    assign bn_next_sat = bn_next[3] ? bn_next : BN_RESET;

    always_comb begin
        byte_ready = 1'b0;
        if (!stop) begin
            case (state_q)
                S_INIT0, S_INIT1, S_WAIT_BYTE: byte_ready = 1'b1;
                S_RUN:                         byte_ready = dec_valid & bn_req_byte;
                default:                       byte_ready = 1'b0;
            endcase
        end
    end

    assign consume        = byte_valid & byte_ready;
    assign dec_ready      = (state_q == S_RUN);
    assign init_done      = (state_q == S_RUN) || (state_q == S_WAIT_BYTE);
    assign m_bitsNeeded   = bn_q;
    assign byte_out       = byte_out_q;
    assign byte_out_valid = byte_out_valid_q;
    assign byte_out_sel   = byte_out_sel_q;
    assign byte_cnt       = byte_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            bn_q             <= BN_RESET;
            pending_bn_q     <= BN_RESET;
            byte_out_q       <= 8'h00;
            byte_out_valid_q <= 1'b0;
            byte_out_sel_q   <= SEL_HI;
            byte_cnt_q       <= 16'h0000;
        end else begin
            byte_out_valid_q <= consume;
            if (consume) begin
                byte_out_q <= byte_data;
                byte_cnt_q <= byte_cnt_q + 16'd1;
            end

            if (stop) begin
                state_q      <= S_IDLE;
                bn_q         <= BN_RESET;
                pending_bn_q <= BN_RESET;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q    <= S_INIT0;
                            bn_q       <= BN_RESET;
                            byte_cnt_q <= 16'h0000;
                        end
                    end
                    S_INIT0: begin
                        if (consume) begin
                            byte_out_sel_q <= SEL_HI;
                            state_q        <= S_INIT1;
                        end
                    end
                    S_INIT1: begin
                        if (consume) begin
                            byte_out_sel_q <= SEL_LO;
                            state_q        <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (dec_valid) begin
                            if (!bn_req_byte) begin
                                bn_q <= bn_next_sat;
                            end else if (byte_valid) begin
                                byte_out_sel_q <= SEL_RUN;
                                bn_q           <= bn_next_sat;
                            end else begin
                                // Park the step's result until its byte shows up.
                                pending_bn_q <= bn_next_sat;
                                state_q      <= S_WAIT_BYTE;
                            end
                        end
                    end
                    S_WAIT_BYTE: begin
                        if (consume) begin
                            byte_out_sel_q <= SEL_RUN;
                            bn_q           <= pending_bn_q;
                            state_q        <= S_RUN;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_byte_fetch_ctrl.sv
// Directed table-driven bench for byte_fetch_ctrl plus async-reset and counter-wrap sequences.
module tb_byte_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, dec_valid, bn_req_byte, byte_valid;
    logic [3:0]  bn_next;
    logic [7:0]  byte_data;
    logic        dec_ready, byte_ready, byte_out_valid, init_done;
    logic [3:0]  m_bitsNeeded;
    logic [7:0]  byte_out;
    logic [1:0]  byte_out_sel;
    logic [15:0] byte_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    byte_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .bn_next        (bn_next),
        .bn_req_byte    (bn_req_byte),
        .m_bitsNeeded   (m_bitsNeeded),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .byte_out       (byte_out),
        .byte_out_valid (byte_out_valid),
        .byte_out_sel   (byte_out_sel),
        .init_done      (init_done),
        .byte_cnt       (byte_cnt)
    );

    typedef struct {
        logic        start, stop, dv, req, bv;
        logic [3:0]  bn;
        logic [7:0]  bd;
        logic        e_brdy, e_drdy;
        logic [3:0]  e_bn;
        logic        e_bov;
        logic [7:0]  e_bo;
        logic [1:0]  e_sel;
        logic        e_init;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic dv, input logic req,
                         input logic [3:0] bn, input logic bv, input logic [7:0] bd);
        start = st; stop = sp; dec_valid = dv; bn_req_byte = req;
        bn_next = bn; byte_valid = bv; byte_data = bd;
    endtask

    function automatic vec_t mk(input logic st, input logic sp, input logic dv, input logic req,
                                input logic [3:0] bn, input logic bv, input logic [7:0] bd,
                                input logic brdy, input logic drdy, input logic [3:0] ebn,
                                input logic bov, input logic [7:0] bo, input logic [1:0] sel,
                                input logic ini, input logic [15:0] cnt);
        vec_t v;
        v.start = st; v.stop = sp; v.dv = dv; v.req = req; v.bn = bn; v.bv = bv; v.bd = bd;
        v.e_brdy = brdy; v.e_drdy = drdy; v.e_bn = ebn; v.e_bov = bov; v.e_bo = bo;
        v.e_sel = sel; v.e_init = ini; v.e_cnt = cnt;
        return v;
    endfunction

    // Clock one cycle with the given inputs, inputs applied on the falling edge.
    task automatic cycle(input logic st, input logic sp, input logic dv, input logic req,
                         input logic [3:0] bn, input logic bv, input logic [7:0] bd);
        @(negedge clk);
        drive(st, sp, dv, req, bn, bv, bd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           st sp dv rq bn     bv bd     brdy drdy e_bn  bov bo     sel ini cnt
        vt[0]  = mk(1, 0, 0, 0, 4'h0, 1, 8'hA5,  0, 0, 4'h8, 0, 8'h00, 0, 0, 16'd0);
        vt[1]  = mk(0, 0, 0, 0, 4'h0, 1, 8'hA5,  1, 0, 4'h8, 1, 8'hA5, 0, 0, 16'd1);
        vt[2]  = mk(0, 0, 0, 0, 4'h0, 1, 8'h3C,  1, 0, 4'h8, 1, 8'h3C, 1, 1, 16'd2);
        vt[3]  = mk(0, 0, 1, 0, 4'hB, 1, 8'h55,  0, 1, 4'hB, 0, 8'h3C, 1, 1, 16'd2);
        vt[4]  = mk(0, 0, 1, 1, 4'h8, 1, 8'h7E,  1, 1, 4'h8, 1, 8'h7E, 2, 1, 16'd3);
        vt[5]  = mk(0, 0, 1, 0, 4'hD, 0, 8'h00,  0, 1, 4'hD, 0, 8'h7E, 2, 1, 16'd3);
        vt[6]  = mk(0, 0, 1, 0, 4'h2, 0, 8'h00,  0, 1, 4'h8, 0, 8'h7E, 2, 1, 16'd3);
        vt[7]  = mk(0, 0, 1, 1, 4'hA, 0, 8'h00,  1, 1, 4'h8, 0, 8'h7E, 2, 1, 16'd3);
        vt[8]  = mk(0, 0, 1, 0, 4'hF, 0, 8'h00,  1, 0, 4'h8, 0, 8'h7E, 2, 1, 16'd3);
        vt[9]  = mk(0, 0, 0, 0, 4'h0, 0, 8'h00,  1, 0, 4'h8, 0, 8'h7E, 2, 1, 16'd3);
        vt[10] = mk(0, 0, 0, 0, 4'h0, 1, 8'h99,  1, 0, 4'hA, 1, 8'h99, 2, 1, 16'd4);
        vt[11] = mk(0, 0, 0, 0, 4'h0, 0, 8'h00,  0, 1, 4'hA, 0, 8'h99, 2, 1, 16'd4);
        vt[12] = mk(0, 0, 1, 1, 4'hE, 0, 8'h00,  1, 1, 4'hA, 0, 8'h99, 2, 1, 16'd4);
        vt[13] = mk(0, 1, 0, 0, 4'h0, 1, 8'h11,  0, 0, 4'h8, 0, 8'h99, 2, 0, 16'd4);
        vt[14] = mk(1, 1, 0, 0, 4'h0, 1, 8'h22,  0, 0, 4'h8, 0, 8'h99, 2, 0, 16'd4);
        vt[15] = mk(1, 0, 0, 0, 4'h0, 0, 8'h00,  0, 0, 4'h8, 0, 8'h99, 2, 0, 16'd0);
        vt[16] = mk(1, 0, 0, 0, 4'h0, 0, 8'h00,  1, 0, 4'h8, 0, 8'h99, 2, 0, 16'd0);
        vt[17] = mk(0, 0, 0, 0, 4'h0, 1, 8'h42,  1, 0, 4'h8, 1, 8'h42, 0, 0, 16'd1);

        rst = 1'b1;
        drive(0, 0, 0, 0, 4'h0, 1, 8'hFF);
        #12;
        chk("rst_bn",   32'(m_bitsNeeded),   32'h8);
        chk("rst_bo",   32'(byte_out),       32'h0);
        chk("rst_bov",  32'(byte_out_valid), 32'h0);
        chk("rst_cnt",  32'(byte_cnt),       32'h0);
        chk("rst_brdy", 32'(byte_ready),     32'h0);
        chk("rst_drdy", 32'(dec_ready),      32'h0);
        chk("rst_init", 32'(init_done),      32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 4'h0, 0, 8'h00);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vt[i].start, vt[i].stop, vt[i].dv, vt[i].req, vt[i].bn, vt[i].bv, vt[i].bd);
            #1;
            chk($sformatf("v%0d_brdy", i), 32'(byte_ready), 32'(vt[i].e_brdy));
            chk($sformatf("v%0d_drdy", i), 32'(dec_ready),  32'(vt[i].e_drdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_bn", i),   32'(m_bitsNeeded),   32'(vt[i].e_bn));
            chk($sformatf("v%0d_bov", i),  32'(byte_out_valid), 32'(vt[i].e_bov));
            chk($sformatf("v%0d_bo", i),   32'(byte_out),       32'(vt[i].e_bo));
            chk($sformatf("v%0d_sel", i),  32'(byte_out_sel),   32'(vt[i].e_sel));
            chk($sformatf("v%0d_init", i), 32'(init_done),      32'(vt[i].e_init));
            chk($sformatf("v%0d_cnt", i),  32'(byte_cnt),       32'(vt[i].e_cnt));
        end

        // Async reset in INIT1 while a byte_out_valid pulse is showing.
        @(negedge clk);
        drive(0, 0, 0, 0, 4'h0, 1, 8'h77);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_bn",   32'(m_bitsNeeded),   32'h8);
        chk("arst_bo",   32'(byte_out),       32'h0);
        chk("arst_bov",  32'(byte_out_valid), 32'h0);
        chk("arst_sel",  32'(byte_out_sel),   32'h0);
        chk("arst_cnt",  32'(byte_cnt),       32'h0);
        chk("arst_brdy", 32'(byte_ready),     32'h0);
        chk("arst_init", 32'(init_done),      32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while parked in WAIT_BYTE abandons the byte.
        cycle(1, 0, 0, 0, 4'h0, 0, 8'h00);
        cycle(0, 0, 0, 0, 4'h0, 1, 8'h01);
        cycle(0, 0, 0, 0, 4'h0, 1, 8'h02);
        cycle(0, 0, 1, 1, 4'hC, 0, 8'h00);
        chk("wait_init", 32'(init_done), 32'h1);
        chk("wait_drdy", 32'(dec_ready), 32'h0);
        chk("wait_bn",   32'(m_bitsNeeded), 32'h8);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 4'h0, 0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 4'h0, 1, 8'h5A);
            chk($sformatf("wrst_bov%0d", i), 32'(byte_out_valid), 32'h0);
            chk($sformatf("wrst_cnt%0d", i), 32'(byte_cnt),       32'h0);
        end

        // Counter wrap: two init bytes then 65533 fetch hits reach 0xFFFF.
        cycle(1, 0, 0, 0, 4'h0, 0, 8'h00);
        cycle(0, 0, 0, 0, 4'h0, 1, 8'h10);
        cycle(0, 0, 0, 0, 4'h0, 1, 8'h20);
        for (int i = 0; i < 65533; i++) begin
            cycle(0, 0, 1, 1, 4'h8, 1, 8'h33);
        end
        chk("wrap_ffff", 32'(byte_cnt), 32'hFFFF);
        cycle(0, 0, 1, 1, 4'h9, 1, 8'hC4);
        chk("wrap_zero", 32'(byte_cnt),       32'h0);
        chk("wrap_bov",  32'(byte_out_valid), 32'h1);
        chk("wrap_bo",   32'(byte_out),       32'hC4);
        chk("wrap_bn",   32'(m_bitsNeeded),   32'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
